// File: rtl/parking_billing.sv
// Parking lot billing: per-slot entry-hour table, exit fee/duration over valid/ready, occupancy.
// Optional PARK_DAILY_CAP_EN clamps each stay's fee to DAILY_CAP.
module parking_billing #(
    parameter int NUM_SLOTS      = 8,
    parameter int SLOT_W         = 3,
    parameter int FIRST_HOUR_FEE = 50,
    parameter int HOURLY_FEE     = 20,
    parameter int DAILY_CAP      = 300
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       clock_time,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_exit,
    input  logic [SLOT_W-1:0] req_slot,
    output logic              fee_valid,
    input  logic              fee_ready,
    output logic [15:0]       fee,
    output logic [4:0]        duration,
    output logic              err,
    output logic [6:0]        occupancy,
    output logic              full
);

`ifdef PARK_DAILY_CAP_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ENTRY, CALC, OUT} state_t;

    state_t             state_q;
    logic               pend_q;
    logic               exit_q;
    logic [SLOT_W-1:0]  slot_q;
    logic [4:0]         hr_q;
    logic [NUM_SLOTS-1:0] vld_q;
    logic [4:0]         entry_q [NUM_SLOTS];
    logic               ready_q;
    logic               fee_valid_q;
    logic               err_q;
    logic [15:0]        fee_q;
    logic [4:0]         dur_q;
    logic [6:0]         occ_q;

    logic [4:0]  hr_in;
    logic        slot_ok;
    logic        slot_busy;
    logic [4:0]  ent;
    logic [5:0]  diff_d;
    logic [4:0]  billed_d;
    logic [15:0] fee_d;

    function automatic logic [15:0] sat16(input logic [31:0] v);
        return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
    endfunction

    function automatic logic [15:0] cap_fee(input logic [15:0] f);
        return (CAP_EN && (32'(f) > 32'(DAILY_CAP))) ? 16'(DAILY_CAP) : f;
    endfunction

    assign hr_in     = (clock_time > 12'd23) ? 5'd23 : clock_time[4:0];
    assign slot_ok   = (int'(slot_q) < NUM_SLOTS);
    assign slot_busy = slot_ok ? vld_q[slot_q] : 1'b0;
    assign ent       = entry_q[slot_q];

    // Duration wraps across midnight; a same-hour stay still bills one hour.
    assign diff_d   = (hr_q >= ent) ? ({1'b0, hr_q} - {1'b0, ent})
                                    : ({1'b0, hr_q} + 6'd24 - {1'b0, ent});
    assign billed_d = (diff_d == 6'd0) ? 5'd1 : diff_d[4:0];
    assign fee_d    = cap_fee(sat16(32'(FIRST_HOUR_FEE)
                                    + (32'(billed_d) - 32'd1) * 32'(HOURLY_FEE)));

    // The accept edge only captures the request; decode happens the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            ready_q     <= 1'b0;
            fee_valid_q <= 1'b0;
            fee_q       <= 16'd0;
            dur_q       <= 5'd0;
            err_q       <= 1'b0;
            occ_q       <= 7'd0;
            vld_q       <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pend_q) begin
                        pend_q <= 1'b0;
                        if (!slot_ok) begin
                            err_q   <= 1'b1;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= exit_q ? CALC : ENTRY;
                        end
                    end else if (req_valid && ready_q) begin
                        pend_q  <= 1'b1;
                        ready_q <= 1'b0;
                        slot_q  <= req_slot;
                        hr_q    <= hr_in;
                        exit_q  <= req_exit;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ENTRY: begin
                    if (slot_busy) begin
                        err_q <= 1'b1;
                    end else begin
                        entry_q[slot_q] <= hr_q;
                        vld_q[slot_q]   <= 1'b1;
                        occ_q           <= occ_q + 7'd1;
                    end
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                CALC: begin
                    if (!slot_busy) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        fee_q         <= fee_d;
                        dur_q         <= billed_d;
                        vld_q[slot_q] <= 1'b0;
                        occ_q         <= occ_q - 7'd1;
                        fee_valid_q   <= 1'b1;
                        state_q       <= OUT;
                    end
                end
                OUT: begin
                    if (fee_ready) begin
                        fee_valid_q <= 1'b0;
                        state_q     <= IDLE;
                        ready_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign fee_valid = fee_valid_q;
    assign fee       = fee_q;
    assign duration  = dur_q;
    assign err       = err_q;
    assign occupancy = occ_q;
    assign full      = (occ_q == 7'(NUM_SLOTS));

endmodule

// File: tb/tb_parking_billing.sv
// Directed bench for parking_billing: entry/exit billing, midnight wrap, errors, full lot, backpressure, reset.
module tb_parking_billing;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] clock_time;
    logic        req_valid;
    logic        req_ready;
    logic        req_exit;
    logic [2:0]  req_slot;
    logic        fee_valid;
    logic        fee_ready;
    logic [15:0] fee;
    logic [4:0]  duration;
    logic        err;
    logic [6:0]  occupancy;
    logic        full;

    int tests = 0;
    int fails = 0;

    parking_billing dut (
        .clk(clk), .rst(rst), .clock_time(clock_time),
        .req_valid(req_valid), .req_ready(req_ready), .req_exit(req_exit), .req_slot(req_slot),
        .fee_valid(fee_valid), .fee_ready(fee_ready), .fee(fee), .duration(duration),
        .err(err), .occupancy(occupancy), .full(full)
    );

    always #5 clk = ~clk;

    // Issue one request from a negedge; returns at the negedge after accept edge + 2.
    task automatic send(input logic ex, input logic [2:0] slot, input logic [11:0] ct);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            $display("FAIL ready_timeout: req_ready=%0b required 1", req_ready);
            fails++;
        end
        tests++;
        req_valid  = 1'b1;
        req_exit   = ex;
        req_slot   = slot;
        clock_time = ct;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic consume();
        fee_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fee_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        if ({req_ready, fee_valid, err, full} !== 4'b0000) begin
            $display("FAIL reset_ctrl: rdy/fv/err/full=%b required 0000", {req_ready, fee_valid, err, full});
            fails++;
        end
        tests++;
        if ({fee, duration, occupancy} !== 28'd0) begin
            $display("FAIL reset_data: fee=%0d dur=%0d occ=%0d required 0", fee, duration, occupancy);
            fails++;
        end
        tests++;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (req_ready !== 1'b1) begin
            $display("FAIL reset_ready: req_ready=%0b required 1", req_ready);
            fails++;
        end
        tests++;
    endtask

    task automatic test_basic();
        send(1'b0, 3'd3, 12'd8);
        if (occupancy !== 7'd1 || err !== 1'b0) begin
            $display("FAIL basic_entry: occ=%0d err=%0b required 1 0", occupancy, err);
            fails++;
        end
        tests++;
        send(1'b1, 3'd3, 12'd11);
        if ({fee_valid, duration, fee, occupancy} !== {1'b1, 5'd3, 16'd90, 7'd0}) begin
            $display("FAIL basic_exit: fv=%0b dur=%0d fee=%0d occ=%0d required 1 3 90 0", fee_valid, duration, fee, occupancy);
            fails++;
        end
        tests++;
        consume();
        if (fee_valid !== 1'b0 || req_ready !== 1'b1) begin
            $display("FAIL basic_handshake: fv=%0b rdy=%0b required 0 1", fee_valid, req_ready);
            fails++;
        end
        tests++;
    endtask

    task automatic test_wrap();
        send(1'b0, 3'd0, 12'd22);
        send(1'b1, 3'd0, 12'd2);
        if ({fee_valid, duration, fee} !== {1'b1, 5'd4, 16'd110}) begin
            $display("FAIL wrap: fv=%0b dur=%0d fee=%0d required 1 4 110", fee_valid, duration, fee);
            fails++;
        end
        tests++;
        consume();
    endtask

    task automatic test_same_hour();
        send(1'b0, 3'd5, 12'd14);
        send(1'b1, 3'd5, 12'd14);
        if ({fee_valid, duration, fee} !== {1'b1, 5'd1, 16'd50}) begin
            $display("FAIL same_hour: fv=%0b dur=%0d fee=%0d required 1 1 50", fee_valid, duration, fee);
            fails++;
        end
        tests++;
        consume();
    endtask

    task automatic test_errors();
        send(1'b0, 3'd2, 12'd5);
        send(1'b0, 3'd2, 12'd7);
        if (err !== 1'b1 || occupancy !== 7'd1) begin
            $display("FAIL dup_entry: err=%0b occ=%0d required 1 1", err, occupancy);
            fails++;
        end
        tests++;
        @(negedge clk);
        if (err !== 1'b0) begin
            $display("FAIL err_pulse: err=%0b required 0", err);
            fails++;
        end
        tests++;
        send(1'b1, 3'd6, 12'd9);
        if (err !== 1'b1 || fee_valid !== 1'b0) begin
            $display("FAIL empty_exit: err=%0b fv=%0b required 1 0", err, fee_valid);
            fails++;
        end
        tests++;
        send(1'b1, 3'd2, 12'd9);
        if ({fee_valid, duration, fee, occupancy} !== {1'b1, 5'd4, 16'd110, 7'd0}) begin
            $display("FAIL dup_keeps_first: fv=%0b dur=%0d fee=%0d occ=%0d required 1 4 110 0", fee_valid, duration, fee, occupancy);
            fails++;
        end
        tests++;
        consume();
    endtask

    task automatic test_full_day();
        logic [15:0] exp_fee;
`ifdef PARK_DAILY_CAP_EN
        exp_fee = 16'd300;
`else
        exp_fee = 16'd490;
`endif
        send(1'b0, 3'd1, 12'd0);
        send(1'b1, 3'd1, 12'd23);
        if ({fee_valid, duration, fee} !== {1'b1, 5'd23, exp_fee}) begin
            $display("FAIL full_day: fv=%0b dur=%0d fee=%0d required 1 23 %0d", fee_valid, duration, fee, exp_fee);
            fails++;
        end
        tests++;
        consume();
    endtask

    task automatic test_clamp();
        send(1'b0, 3'd4, 12'd20);
        send(1'b1, 3'd4, 12'd100);
        if ({fee_valid, duration, fee} !== {1'b1, 5'd3, 16'd90}) begin
            $display("FAIL hour_clamp: fv=%0b dur=%0d fee=%0d required 1 3 90", fee_valid, duration, fee);
            fails++;
        end
        tests++;
        consume();
    endtask

    task automatic test_full_lot();
        for (int s = 0; s < 8; s++) send(1'b0, 3'(s), 12'd10);
        if (occupancy !== 7'd8 || full !== 1'b1) begin
            $display("FAIL lot_full: occ=%0d full=%0b required 8 1", occupancy, full);
            fails++;
        end
        tests++;
        send(1'b0, 3'd3, 12'd11);
        if (err !== 1'b1 || occupancy !== 7'd8) begin
            $display("FAIL full_dup: err=%0b occ=%0d required 1 8", err, occupancy);
            fails++;
        end
        tests++;
        send(1'b1, 3'd3, 12'd12);
        if ({duration, fee, occupancy, full} !== {5'd2, 16'd70, 7'd7, 1'b0}) begin
            $display("FAIL full_exit: dur=%0d fee=%0d occ=%0d full=%0b required 2 70 7 0", duration, fee, occupancy, full);
            fails++;
        end
        tests++;
        consume();
        for (int s = 0; s < 8; s++) begin
            if (s != 3) begin
                send(1'b1, 3'(s), 12'd13);
                consume();
            end
        end
        if (occupancy !== 7'd0) begin
            $display("FAIL lot_drain: occ=%0d required 0", occupancy);
            fails++;
        end
        tests++;
    endtask

    task automatic test_backpressure();
        send(1'b0, 3'd2, 12'd9);
        send(1'b0, 3'd7, 12'd1);
        send(1'b1, 3'd7, 12'd6);
        if ({fee_valid, duration, fee, occupancy} !== {1'b1, 5'd5, 16'd130, 7'd1}) begin
            $display("FAIL bp_result: fv=%0b dur=%0d fee=%0d occ=%0d required 1 5 130 1", fee_valid, duration, fee, occupancy);
            fails++;
        end
        tests++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ({fee_valid, req_ready, duration, fee} !== {1'b1, 1'b0, 5'd5, 16'd130}) begin
                $display("FAIL bp_hold%0d: fv=%0b rdy=%0b dur=%0d fee=%0d required 1 0 5 130", i, fee_valid, req_ready, duration, fee);
                fails++;
            end
            tests++;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if ({fee_valid, req_ready, occupancy} !== {1'b0, 1'b0, 7'd0}) begin
            $display("FAIL rst_in_out: fv=%0b rdy=%0b occ=%0d required 0 0 0", fee_valid, req_ready, occupancy);
            fails++;
        end
        tests++;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        send(1'b1, 3'd2, 12'd12);
        if (err !== 1'b1 || fee_valid !== 1'b0) begin
            $display("FAIL table_cleared: err=%0b fv=%0b required 1 0", err, fee_valid);
            fails++;
        end
        tests++;
    endtask

    task automatic test_back_to_back();
        send(1'b0, 3'd6, 12'd3);
        @(negedge clk);
        req_valid = 1'b1;
        req_exit  = 1'b1;
        req_slot  = 3'd6;
        clock_time = 12'd3;
        @(posedge clk);
        @(negedge clk);
        if (req_ready !== 1'b0) begin
            $display("FAIL b2b_busy: req_ready=%0b required 0", req_ready);
            fails++;
        end
        tests++;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        if ({fee_valid, duration, fee} !== {1'b1, 5'd1, 16'd50}) begin
            $display("FAIL b2b_exit: fv=%0b dur=%0d fee=%0d required 1 1 50", fee_valid, duration, fee);
            fails++;
        end
        tests++;
        consume();
    endtask

    initial begin
        rst        = 1'b1;
        clock_time = 12'd0;
        req_valid  = 1'b0;
        req_exit   = 1'b0;
        req_slot   = 3'd0;
        fee_ready  = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_same_hour();
        test_errors();
        test_full_day();
        test_clamp();
        test_full_lot();
        test_backpressure();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
